// File: rtl/shift_exec_unit.sv
// rtl/shift_exec_unit.sv - two-stage RV32I SLL/SRL/SRA execute unit built on one left barrel shifter
// Right shifts run through the left shifter by reversing the operand before and after.
module shift_exec_unit #(
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [31:0]      in_a,
   input  logic [4:0]       in_shamt,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_result,
   output logic [TAG_W-1:0] out_tag
);

   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;
   localparam logic [1:0] OP_RSV = 2'b11;

   function automatic logic [31:0] bit_rev(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) begin
         r[i] = v[31-i];
      end
      return r;
   endfunction

   // S1: conditioned operand and decoded op
   logic             s1_valid;
   logic [1:0]       s1_op;
   logic [4:0]       s1_shamt;
   logic [TAG_W-1:0] s1_tag;
   logic [31:0]      s1_a;
   logic             s1_sign;

   // S2: registered result
   logic             s2_valid;
   logic [31:0]      s2_result;
   logic [TAG_W-1:0] s2_tag;

   logic             s2_adv;
   logic             s1_adv;
   logic [31:0]      in_cond;
   logic [31:0]      shl;
   logic [31:0]      s2_next;

   assign s2_adv   = !s2_valid || out_ready;
   assign s1_adv   = !s1_valid || s2_adv;
   assign in_ready = s1_adv && !flush;

   assign in_cond  = (in_op == OP_SRL || in_op == OP_SRA) ? bit_rev(in_a) : in_a;

   always_comb begin
      shl     = s1_a << s1_shamt;
      s2_next = shl;
      case (s1_op)
         OP_SLL:  s2_next = shl;
         OP_SRL:  s2_next = bit_rev(shl);
         // sign fill covers the top shamt bits; the mask is empty when shamt = 0
         OP_SRA:  s2_next = bit_rev(shl) | (s1_sign ? ~(32'hFFFF_FFFF >> s1_shamt) : 32'h0);
         OP_RSV:  s2_next = s1_a;
         default: s2_next = shl;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_op     <= 2'b00;
         s1_shamt  <= 5'd0;
         s1_tag    <= '0;
         s1_a      <= 32'h0;
         s1_sign   <= 1'b0;
         s2_valid  <= 1'b0;
         s2_result <= 32'h0;
         s2_tag    <= '0;
      end else if (flush) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else begin
         if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               s2_result <= s2_next;
               s2_tag    <= s1_tag;
            end
         end
         if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
               s1_op    <= in_op;
               s1_shamt <= in_shamt;
               s1_tag   <= in_tag;
               s1_a     <= in_cond;
               s1_sign  <= in_a[31];
            end
         end
      end
   end

   assign out_valid  = s2_valid;
   assign out_result = s2_result;
   assign out_tag    = s2_tag;

endmodule

// File: tb/tb_shift_exec_unit.sv
// tb/tb_shift_exec_unit.sv - randomized scoreboard bench for shift_exec_unit
// Expected results come from plain shift operators; occupancy/latency from a queue of accept times.
module tb_shift_exec_unit;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_op;
   logic [31:0] in_a;
   logic [4:0]  in_shamt;
   logic [4:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [4:0]  out_tag;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  tag;
      int          stamp;
   } item_t;

   item_t q[$];

   shift_exec_unit #(.TAG_W(5)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_a       (in_a),
      .in_shamt   (in_shamt),
      .in_tag     (in_tag),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_tag    (out_tag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] a,
                                             input logic [4:0] sh);
      logic signed [31:0] sa;
      sa = a;
      case (op)
         2'b00:   return a << sh;
         2'b01:   return a >> sh;
         2'b10:   return sa >>> sh;
         default: return a;
      endcase
   endfunction

   // scoreboard: sample everything mid-cycle, away from the rising edge
   always @(negedge clk) begin
      logic exp_rdy;
      logic exp_v;
      if (!rst_n) begin
         q.delete();
         check("rst_out_valid", 32'(out_valid), 32'd0);
         check("rst_out_result", out_result, 32'd0);
      end else begin
         exp_rdy = !flush && (q.size() < 2 || out_ready);
         exp_v   = q.size() > 0 && q[0].stamp < cyc;
         check("in_ready", 32'(in_ready), 32'(exp_rdy));
         check("out_valid", 32'(out_valid), 32'(exp_v));
         if (exp_v && out_valid) begin
            check("out_result", out_result, q[0].res);
            check("out_tag", 32'(out_tag), 32'(q[0].tag));
         end
         if (exp_v && out_ready) void'(q.pop_front());
         if (flush) q.delete();
         else if (in_valid && exp_rdy)
            q.push_back('{ref_shift(in_op, in_a, in_shamt), in_tag, cyc + 1});
      end
   end

   task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a,
                        input logic [4:0] sh, input logic [4:0] tag,
                        input logic ordy, input logic fl);
      in_valid  = v;
      in_op     = op;
      in_a      = a;
      in_shamt  = sh;
      in_tag    = tag;
      out_ready = ordy;
      flush     = fl;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic ordy, input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 2'b00, 32'h0, 5'd0, 5'd0, ordy, 1'b0);
   endtask

   logic [31:0] vec_a [8];
   logic [4:0]  vec_s [8];
   logic [1:0]  vec_o [8];
   logic [31:0] held;

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0; in_op = 2'b00; in_a = 32'h0; in_shamt = 5'd0; in_tag = 5'd0;
      out_ready = 1'b0; flush = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_out_result", out_result, 32'd0);
      check("reset_out_tag", 32'(out_tag), 32'd0);
      rst_n = 1'b1;
      #1;
      check("reset_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;

      // SLL 1 by 31, latency of exactly two cycles
      drive(1'b1, 2'b00, 32'h0000_0001, 5'd31, 5'd7, 1'b1, 1'b0);
      check("lat_n1_valid", 32'(out_valid), 32'd0);
      idle(1'b1, 1);
      check("lat_n2_valid", 32'(out_valid), 32'd1);
      check("sll31_result", out_result, 32'h8000_0000);
      check("sll31_tag", 32'(out_tag), 32'd7);
      idle(1'b1, 2);

      // boundary vectors
      vec_o = '{2'b01, 2'b10, 2'b10, 2'b00, 2'b01, 2'b10, 2'b11, 2'b01};
      vec_a = '{32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'hDEAD_BEEF,
                32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h8000_0001};
      vec_s = '{5'd4, 5'd4, 5'd31, 5'd0, 5'd0, 5'd0, 5'd13, 5'd31};
      for (int i = 0; i < 8; i++) drive(1'b1, vec_o[i], vec_a[i], vec_s[i], 5'(i), 1'b1, 1'b0);
      idle(1'b1, 3);

      // SRA of 0x8000_0000 by 4 against a fixed value
      drive(1'b1, 2'b10, 32'h8000_0000, 5'd4, 5'd9, 1'b1, 1'b0);
      idle(1'b1, 1);
      check("sra4_result", out_result, 32'hF800_0000);
      idle(1'b1, 2);

      // five back-to-back ops
      for (int i = 1; i <= 5; i++) drive(1'b1, 2'(i % 3), $urandom, 5'($urandom), 5'(i), 1'b1, 1'b0);
      idle(1'b1, 3);

      // stall: three ops offered while out_ready is low
      drive(1'b1, 2'b00, 32'h0000_00F1, 5'd1, 5'd1, 1'b0, 1'b0);
      drive(1'b1, 2'b01, 32'hF000_0002, 5'd2, 5'd2, 1'b0, 1'b0);
      held = out_result;
      drive(1'b1, 2'b10, 32'h8000_0003, 5'd3, 5'd3, 1'b0, 1'b0);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      drive(1'b1, 2'b10, 32'h8000_0003, 5'd3, 5'd3, 1'b0, 1'b0);
      check("stall_hold", out_result, held);
      drive(1'b1, 2'b10, 32'h8000_0003, 5'd3, 5'd3, 1'b1, 1'b0);
      idle(1'b1, 4);

      // flush with both stages full
      drive(1'b1, 2'b00, 32'h1111_1111, 5'd1, 5'd20, 1'b0, 1'b0);
      drive(1'b1, 2'b00, 32'h2222_2222, 5'd2, 5'd21, 1'b0, 1'b0);
      drive(1'b1, 2'b00, 32'h3333_3333, 5'd3, 5'd22, 1'b0, 1'b0);
      in_valid = 1'b1; in_tag = 5'd23; flush = 1'b1;
      #1;
      check("flush_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      check("flush_out_valid", 32'(out_valid), 32'd0);
      drive(1'b1, 2'b01, 32'hCAFE_F00D, 5'd8, 5'd24, 1'b1, 1'b0);
      idle(1'b1, 3);

      // asynchronous reset with two ops in flight
      drive(1'b1, 2'b00, 32'h0000_0005, 5'd1, 5'd25, 1'b0, 1'b0);
      drive(1'b1, 2'b00, 32'h0000_0006, 5'd1, 5'd26, 1'b0, 1'b0);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", 32'(out_valid), 32'd0);
      check("arst_out_result", out_result, 32'd0);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      drive(1'b1, 2'b10, 32'h8765_4321, 5'd5, 5'd27, 1'b1, 1'b0);
      idle(1'b1, 1);
      check("post_rst_valid", 32'(out_valid), 32'd1);
      idle(1'b1, 2);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic [4:0] sh;
         case ($urandom_range(0, 3))
            0:       sh = 5'd0;
            1:       sh = 5'd31;
            default: sh = 5'($urandom);
         endcase
         drive(1'($urandom_range(0, 3) != 0), 2'($urandom), $urandom, sh, 5'($urandom),
               1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));
      end
      idle(1'b1, 5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/shift_exec_unit.md
Name: shift_exec_unit

Overview:
- Pipelined execute-stage shift unit for the RV32I core. Covers SLL/SLLI, SRL/SRLI and SRA/SRAI.
- Sits between the issue/operand-read stage and the writeback mux.
- Decodes the shift op and conditions the operand so that one internal 32-bit left barrel shift serves all three ops. Right shifts use bit reversal before and after the shift. SRA adds a sign-fill mask.
- Valid/ready handshakes on both sides; two register stages.

Parameters:
TAG_W, 5, width of destination-register tag carried alongside the operation.

Ports:
clk  input  1  core clock, all state on rising edge
rst_n  input  1  reset, asynchronous, active-low
flush  input  1  synchronous pipeline kill (branch mispredict/trap)
in_valid  input  1  upstream presents an operation
in_ready  output  1  unit can accept an operation this cycle
in_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 reserved
in_a  input  32  operand to shift (rs1)
in_shamt  input  5  shift amount (rs2[4:0] or imm[4:0])
in_tag  input  TAG_W  destination register tag
out_valid  output  1  result available
out_ready  input  1  downstream accepts result
out_result  output  32  shifted value
out_tag  output  TAG_W  tag of out_result

Behaviour:
- Clock and reset: one clock (clk); reset (rst_n) is asynchronous and active-low.
- Reset values:
  - All stage valid flags = 0, so out_valid = 0.
  - out_result = 0, out_tag = 0.
  - in_ready = 1 once rst_n deasserts.
  - Data registers are cleared.
- Transfers: an input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- Stage S1 (condition), loaded on input transfer:
  - Stores the op, shamt and tag.
  - Stores the conditioned operand: in_a bit-reversed for SRL/SRA, unmodified for SLL/reserved.
  - Stores the sign bit, in_a[31].
- Stage S2 (shift/output), loaded from S1 when S1 is valid and S2 can advance:
  - Computes the left shift of the conditioned operand by shamt, zero fill.
  - For SRL/SRA, bit-reverses the shifted value back.
  - For SRA with sign = 1, ORs ones into bits [31:32-shamt] (no fill when shamt = 0).
  - Reserved op: result = in_a, shamt ignored.
  - S2 drives out_result/out_tag directly from registers; no combinational path from inputs to outputs.
- Latency: accepted in cycle N, out_valid asserted in cycle N+2 when there is no backpressure.
- Throughput: 1 op per cycle.
- Backpressure:
  - S2 can advance = !S2.valid || out_ready.
  - S1 can advance = !S1.valid || S2 can advance.
  - in_ready = S1 can advance. This is combinational from out_ready; a single-cycle ready path is accepted.
- Stall hold: while out_valid && !out_ready, out_result and out_tag hold stable. S1 holds if full.
  - Max occupancy is 2 ops.
  - No loss, no duplication; order is strictly preserved.
- Simultaneous events:
  - Output transfer and S1→S2 move in the same cycle are legal; S2 is replaced with no bubble.
  - Input transfer and S1→S2 move in the same cycle are legal.
- flush:
  - Clears both valid flags at the next edge, so out_valid = 0 the following cycle.
  - Any input presented in the flush cycle is dropped, and in_ready is forced to 0 in that cycle.
  - flush takes priority over all transfers. An output transfer in the flush cycle still counts as completed for downstream.
- Shift boundaries:
  - shamt = 0 returns in_a for all ops.
  - shamt = 31: SLL leaves only bit 31 = in_a[0]; SRL leaves bit 0 = in_a[31]; SRA gives all-sign.
- Reset mid-operation: all in-flight ops are discarded and out_valid drops asynchronously. Nothing is replayed after reset.

Test Plan:
- SLL, a=0x0000_0001, shamt=31, out_ready=1 → out_result=0x8000_0000, tag preserved, out_valid exactly 2 cycles after acceptance.
- SRL and SRA, a=0x8000_0000, shamt=4 → 0x0800_0000 and 0xF800_0000 respectively. SRA a=0x7FFF_FFFF, shamt=31 → 0x0000_0000. Any op with shamt=0, a=0xDEAD_BEEF → 0xDEAD_BEEF.
- Five back-to-back ops with tags 1..5, out_ready=1 → results on five consecutive cycles, in order, in_ready never deasserts.
- out_ready=0 for 4 cycles while 3 ops offered → first two accepted, then in_ready=0. out_result stable while stalled. After release, tags emerge in order 1,2,3 with no gap and none lost or duplicated.
- Both stages full, flush=1 for one cycle with in_valid=1 → out_valid=0 next cycle, in_ready=0 in flush cycle, none of the flushed tags ever appear, next op latency is 2.
- rst_n pulsed low between clock edges with 2 ops in flight → out_valid falls immediately (asynchronous), out_result=0. After release, the first new op completes normally.
